// File: rtl/oc_uart_rx.sv
// oc_uart_rx: receive front-end for a single UART pin.
// Synchronizes the raw line, deframes 8N1 characters using a mid-bit
// sampling timer, buffers completed bytes in a small FIFO and presents them
// as a valid/ready byte stream with one-cycle error pulses.
module oc_uart_rx #(
    parameter int ClockHz    = 156250000,
    parameter int Baud       = 460800,
    parameter int SyncStages = 3,
    parameter int FifoDepth  = 4
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       uartRx,
    output logic [7:0] rxData,
    output logic       rxValid,
    input  logic       rxReady,
    output logic       framingError,
    output logic       overflowError,
    output logic       rxBusy
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    // Clock cycles per bit, rounded to the nearest integer.
    localparam int CyclesPerBit = (ClockHz + Baud / 2) / Baud;
    localparam int TimerWidth   = $clog2(CyclesPerBit);
    localparam int IndexWidth   = $clog2(FifoDepth);
    localparam int PtrWidth     = IndexWidth + 1;

    // Half a bit minus one lands the start-bit check mid-bit; every later
    // sample is one full bit period after the previous one.
    localparam logic [TimerWidth-1:0] HalfLoad = TimerWidth'(CyclesPerBit / 2 - 1);
    localparam logic [TimerWidth-1:0] FullLoad = TimerWidth'(CyclesPerBit - 1);
    localparam logic [TimerWidth-1:0] TimerOne = TimerWidth'(1);
    localparam logic [PtrWidth-1:0]   PtrOne   = PtrWidth'(1);
    localparam logic [2:0]            LastBit  = 3'd7;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (CyclesPerBit < 8) begin : g_bad_rate
            $error("oc_uart_rx: ClockHz/Baud must give at least 8 cycles per bit");
        end
        if (SyncStages < 2 || SyncStages > 4) begin : g_bad_sync
            $error("oc_uart_rx: SyncStages must be in 2..4");
        end
        if (FifoDepth < 2 || FifoDepth > 16 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
            $error("oc_uart_rx: FifoDepth must be a power of two in 2..16");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [SyncStages-1:0] sync_reg;
    logic                  rx_sync;

    // Metastability chain; resets to all ones so the line reads idle.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SyncStages-2:0], uartRx};
        end
    end

    assign rx_sync = sync_reg[SyncStages-1];

    // ------------------------------------------------------------------
    // Deframer state machine
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                state_reg, state_next;
    logic [TimerWidth-1:0] timer_reg, timer_next;
    logic [2:0]            bit_index_reg, bit_index_next;
    logic [7:0]            shift_reg, shift_next;
    logic                  expired;
    logic                  push;
    logic                  frame_bad;

    // Deframer state, bit timer, bit index and shift register.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            bit_index_reg <= '0;
            shift_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            bit_index_reg <= bit_index_next;
            shift_reg     <= shift_next;
        end
    end

    assign expired = (timer_reg == '0);

    // Next-state logic; push and frame_bad are single-cycle strobes raised
    // on the stop-sample cycle.
    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        bit_index_next = bit_index_reg;
        shift_next     = shift_reg;
        push           = 1'b0;
        frame_bad      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!rx_sync) begin
                    timer_next = HalfLoad;
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (expired) begin
                    if (rx_sync) begin
                        // Line went back high before mid start bit: a glitch.
                        state_next = ST_IDLE;
                    end else begin
                        timer_next     = FullLoad;
                        bit_index_next = '0;
                        state_next     = ST_DATA;
                    end
                end else begin
                    timer_next = timer_reg - TimerOne;
                end
            end

            ST_DATA: begin
                if (expired) begin
                    // LSB arrives first, so shift in from the top.
                    shift_next = {rx_sync, shift_reg[7:1]};
                    timer_next = FullLoad;
                    if (bit_index_reg == LastBit) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_index_next = bit_index_reg + 3'd1;
                    end
                end else begin
                    timer_next = timer_reg - TimerOne;
                end
            end

            ST_STOP: begin
                if (expired) begin
                    if (rx_sync) begin
                        push       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = ST_BREAK;
                    end
                end else begin
                    timer_next = timer_reg - TimerOne;
                end
            end

            ST_BREAK: begin
                // A held-low line stays here, so it reports only one error.
                if (rx_sync) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rxBusy = (state_reg != ST_IDLE);

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [PtrWidth-1:0]   wr_ptr_reg;
    logic [PtrWidth-1:0]   rd_ptr_reg;
    logic [IndexWidth-1:0] wr_index;
    logic [IndexWidth-1:0] rd_index;
    logic [7:0]            mem [FifoDepth];
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  write;
    logic                  drop;

    assign wr_index = wr_ptr_reg[IndexWidth-1:0];
    assign rd_index = rd_ptr_reg[IndexWidth-1:0];

    // The extra pointer bit distinguishes full from empty at equal indices.
    assign full  = (wr_ptr_reg[IndexWidth] != rd_ptr_reg[IndexWidth]) && (wr_index == rd_index);
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign pop   = !empty && rxReady;

    // A pop in the same cycle frees the slot the push needs.
    assign write = push && (!full || pop);
    assign drop  = push && full && !pop;

    // Read and write pointers.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (write) begin
                wr_ptr_reg <= wr_ptr_reg + PtrOne;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PtrOne;
            end
        end
    end

    // Storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            for (int i = 0; i < FifoDepth; i++) begin
                mem[i] <= '0;
            end
        end else if (write) begin
            for (int i = 0; i < FifoDepth; i++) begin
                if (wr_index == IndexWidth'(i)) begin
                    mem[i] <= shift_reg;
                end
            end
        end
    end

    // The head entry only changes on a pop, so it is stable under backpressure.
    assign rxData  = mem[rd_index];
    assign rxValid = !empty;

    // ------------------------------------------------------------------
    // Error pulses
    // ------------------------------------------------------------------
    logic framing_reg;
    logic overflow_reg;

    // Register the error strobes into one-cycle output pulses.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            framing_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            framing_reg  <= frame_bad;
            overflow_reg <= drop;
        end
    end

    assign framingError  = framing_reg;
    assign overflowError = overflow_reg;

endmodule

// File: doc/oc_uart_rx.md
Name: oc_uart_rx

Overview:
- Receive front-end for one board UART pin, taking the raw pad-side uartRx bit that the chip top feeds into oc_cos.
- Synchronizes the asynchronous line and oversamples it at the configured baud.
- Deframes 8N1 characters and buffers them in a small FIFO.
- Presents them on a valid/ready byte stream to the COS control/debug logic, with pulsed error indications.

Parameters:
- ClockHz, 156250000, frequency of clock in Hz.
- Baud, 460800, line rate in bits/s.
- SyncStages, 3, number of metastability flops on uartRx; legal range 2..4.
- FifoDepth, 4, receive buffer entries; power of two, 2..16.

Ports:
- clock  input  1  block clock, all logic on posedge.
- resetN  input  1  synchronous active-low reset.
- uartRx  input  1  raw asynchronous serial input; idle high.
- rxData  output  8  head-of-FIFO byte.
- rxValid  output  1  rxData holds a valid byte.
- rxReady  input  1  consumer accepts the byte on a cycle with rxValid&&rxReady.
- framingError  output  1  one-cycle pulse: stop bit sampled low.
- overflowError  output  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- rxBusy  output  1  high while the deframer is not in IDLE.

Behaviour:
- Interface:
  - Single clock domain on clock.
  - Reset is resetN: synchronous, active-low, sampled on posedge clock. No asynchronous reset path.
- Bit timing:
  - CyclesPerBit = (ClockHz + Baud/2) / Baud, i.e. rounded.
  - Static assert CyclesPerBit >= 8.
  - The bit counter width is clog2(CyclesPerBit).
- Synchronizer:
  - SyncStages flops, all reset to 1, so the line reads idle after reset.
  - rxSync is the last stage. Only rxSync is used downstream.
- State machine, states IDLE, START, DATA, STOP, BREAK:
  - IDLE: when rxSync==0, load the timer with CyclesPerBit/2 - 1 and go to START.
  - START: at timer expiry, re-sample rxSync.
    - If 1 (glitch or false start), go to IDLE with no output.
    - If 0, load the timer with CyclesPerBit-1, clear bitIndex, go to DATA.
  - DATA: at each timer expiry, shift in rxSync LSB-first, reload the timer, increment bitIndex. After bit 7, go to STOP.
  - STOP: at timer expiry, sample rxSync.
    - If 1, push the byte and go to IDLE.
    - If 0, pulse framingError for one cycle, discard the byte, go to BREAK.
  - BREAK: wait until rxSync==1, then go to IDLE. A held-low break line produces exactly one framingError.
  - The timer counts down; expiry is timer==0.
- FIFO:
  - FifoDepth entries with read/write pointers plus one extra wrap bit.
  - full = (wrap bits differ) && (indices equal). empty = (pointers equal).
  - Push happens on the stop-sample cycle. rxValid rises on the next cycle when the FIFO was empty, giving a latency of 1 clock from the stop sample to rxValid.
  - rxData and rxValid are driven from the FIFO head.
  - rxData must stay stable while rxValid && !rxReady.
  - Pop on rxValid&&rxReady.
- Simultaneous push and pop:
  - When full, the pop frees a slot and the push is accepted; no overflow.
  - When empty, push and pop cannot collide, because rxValid is low.
- Overflow: a push while full and with no pop in the same cycle drops the new byte and pulses overflowError. Existing FIFO contents are untouched.
- Reset values: rxData=0, rxValid=0, framingError=0, overflowError=0, rxBusy=0, FIFO empty, state IDLE.
- Reset mid-character:
  - The in-flight byte is lost and the FIFO is cleared.
  - After reset releases, the remaining line bits may look like a start bit. Any resulting false frame is discarded by the START re-check or the framing check, and the block never hangs.
- Arithmetic: all counters wrap-free by construction; bitIndex is 3 bits with an explicit terminal compare.

Test Plan:
- Nominal frame:
  - Setup: ClockHz=1000000, Baud=100000 (10 cycles/bit); send 0xA5 8N1 with rxReady=1.
  - Required: rxValid high for one cycle, 1 clock after the stop sample, with rxData=0xA5; no error pulses; rxBusy high for roughly 95 cycles.
- Glitch rejection: drive uartRx low for 3 cycles and then high.
  - Required: returns to IDLE at the START check; rxValid and framingError never assert.
- Framing and break: send 0x3C with the stop bit low, then hold the line low for 50 cycles.
  - Required: exactly one framingError pulse; no byte pushed; the next frame, 0x81, is received correctly.
- Backpressure and overflow (FifoDepth=4): rxReady=0, send 0x01..0x05.
  - Required: a single overflowError pulse on the byte 0x05.
  - Then raise rxReady: pops yield 0x01,0x02,0x03,0x04 in order, then rxValid=0.
- Simultaneous push and pop: with the FIFO full, assert rxReady on the stop-sample cycle of a 6th byte.
  - Required: no overflowError; the 6th byte is delivered after the 4 older bytes.
- Reset mid-frame: assert resetN=0 for 2 cycles during data bit 3 of 0xF0.
  - Required: all outputs reset the cycle after; the FIFO is empty; a following 0x5A is received intact.
